// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, decoder state encoding and CRC constants.
// Used by vga_sync_decoder and its optional VGA_DEC_CRC_EN CRC engine.
package vga_pkg;

    localparam int DEF_PIXEL_W  = 3;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } dec_state_t;

    function automatic int h_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    // Index width for 0..n-1, never narrower than one bit.
    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the value n itself (counter saturation point).
    function automatic int cnt_w(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync/pixel bundle between a VGA source and vga_sync_decoder.
// Frame CRC signals exist only when VGA_DEC_CRC_EN is defined.
interface vga_sync_decoder_if #(
    parameter int PIXEL_W = 3,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);

    logic               h_in;
    logic               v_in;
    logic [PIXEL_W-1:0] pixel_in;

    logic               pix_valid;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [PIXEL_W-1:0] pix_data;
    logic               frame_start;
    logic               locked;
    logic               h_err;
    logic               v_err;
    logic [7:0]         err_cnt;
`ifdef VGA_DEC_CRC_EN
    logic [15:0]        frame_crc;
    logic               crc_valid;
`endif

    modport master (
        output h_in, v_in, pixel_in,
`ifdef VGA_DEC_CRC_EN
        input  frame_crc, crc_valid,
`endif
        input  pix_valid, pix_x, pix_y, pix_data,
        input  frame_start, locked, h_err, v_err, err_cnt
    );

    modport slave (
        input  h_in, v_in, pixel_in,
`ifdef VGA_DEC_CRC_EN
        output frame_crc, crc_valid,
`endif
        output pix_valid, pix_x, pix_y, pix_data,
        output frame_start, locked, h_err, v_err, err_cnt
    );

endinterface

// File: rtl/vga_frame_crc.sv
// CRC-16-CCITT over decoded pixels, MSB first, restarted by clear.
// Built into vga_sync_decoder only with VGA_DEC_CRC_EN.
module vga_frame_crc
    import vga_pkg::*;
#(
    parameter int PIXEL_W = 3
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [PIXEL_W-1:0] pixel,
    input  logic               valid,
    input  logic               clear,
    output logic [15:0]        crc
);

    logic [15:0] crc_r;
    logic [15:0] crc_nxt;

    // clear arrives with the first pixel, so it seeds that pixel's update.
    always_comb begin
        crc_nxt = clear ? CRC16_INIT : crc_r;
        for (int i = PIXEL_W - 1; i >= 0; i--) begin
            if (crc_nxt[15] ^ pixel[i]) begin
                crc_nxt = {crc_nxt[14:0], 1'b0} ^ CRC16_POLY;
            end else begin
                crc_nxt = {crc_nxt[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            crc_r <= '0;
        end else if (valid) begin
            crc_r <= crc_nxt;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from hsync/vsync/pixel and checks frame timing.
// Define VGA_DEC_CRC_EN to add the per-frame CRC outputs.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int PIXEL_W  = DEF_PIXEL_W,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic nRst,
    vga_sync_decoder_if.slave bus
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;
    localparam int HW      = cnt_w(H_TOTAL);
    localparam int VW      = cnt_w(V_TOTAL);
    localparam int XW      = idx_w(H_ACTIVE);
    localparam int YW      = idx_w(V_ACTIVE);

    localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYN  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_LO   = HW'(HA0);
    localparam logic [HW-1:0] H_HI   = HW'(HA0 + H_ACTIVE);
    localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYN  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_LO   = VW'(VA0);
    localparam logic [VW-1:0] V_HI   = VW'(VA0 + V_ACTIVE);

    logic               h_q, v_q, h_qq, v_qq;
    logic [PIXEL_W-1:0] d_q;
    logic               h_fall, h_rise, v_fall, v_rise;

    logic [HW-1:0] h_cnt_r, h_cnt;
    logic [VW-1:0] v_cnt_r, v_cnt;
    logic          h_over_r, v_over_r;
    logic          h_err, v_err;

    dec_state_t state_r, state_nxt;

    logic               in_win, lock_nxt, pv_nxt, fs_nxt;
    logic [XW-1:0]      x_nxt;
    logic [YW-1:0]      y_nxt;
    logic [PIXEL_W-1:0] d_nxt;

    logic               pix_valid_r, frame_start_r, locked_r;
    logic               h_err_r, v_err_r;
    logic [XW-1:0]      pix_x_r;
    logic [YW-1:0]      pix_y_r;
    logic [PIXEL_W-1:0] pix_data_r;
    logic [7:0]         err_cnt_r;

    // Sync history resets to idle-high so reset itself is never an edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            h_q  <= 1'b1;
            v_q  <= 1'b1;
            h_qq <= 1'b1;
            v_qq <= 1'b1;
            d_q  <= '0;
        end else begin
            h_q  <= bus.h_in;
            v_q  <= bus.v_in;
            h_qq <= h_q;
            v_qq <= v_q;
            d_q  <= bus.pixel_in;
        end
    end

    assign h_fall = h_qq & ~h_q;
    assign h_rise = ~h_qq & h_q;
    assign v_fall = v_qq & ~v_q;
    assign v_rise = ~v_qq & v_q;

    always_comb begin
        if (h_fall) begin
            h_cnt = '0;
        end else if (h_cnt_r == H_MAX) begin
            h_cnt = H_MAX;
        end else begin
            h_cnt = h_cnt_r + HW'(1);
        end
    end

    always_comb begin
        if (v_fall) begin
            v_cnt = '0;
        end else if (h_fall && (v_cnt_r != V_MAX)) begin
            v_cnt = v_cnt_r + VW'(1);
        end else begin
            v_cnt = v_cnt_r;
        end
    end

    // The over flags make the saturation error a single pulse per run-away.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            h_cnt_r  <= H_MAX;
            v_cnt_r  <= V_MAX;
            h_over_r <= 1'b1;
            v_over_r <= 1'b1;
        end else begin
            h_cnt_r  <= h_cnt;
            v_cnt_r  <= v_cnt;
            h_over_r <= (h_cnt == H_MAX);
            v_over_r <= (v_cnt == V_MAX);
        end
    end

    always_comb begin
        h_err = 1'b0;
        v_err = 1'b0;
        if (state_r != SEARCH) begin
            h_err = (h_fall && (h_cnt_r != H_LAST))
                 || (h_rise && (h_cnt != H_SYN))
                 || ((h_cnt == H_MAX) && !h_over_r);
            v_err = (v_fall && (v_cnt_r != V_LAST))
                 || (v_rise && (v_cnt != V_SYN))
                 || ((v_cnt == V_MAX) && !v_over_r);
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= SEARCH;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            SEARCH: if (v_fall) state_nxt = CHECK;
            CHECK: begin
                if (h_err || v_err) begin
                    state_nxt = SEARCH;
                end else if (v_fall) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: if (h_err || v_err) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
    end

    // Outputs follow the next state so an unlock lands with its error pulse.
    always_comb begin
        in_win   = (h_cnt >= H_LO) && (h_cnt < H_HI)
                && (v_cnt >= V_LO) && (v_cnt < V_HI);
        lock_nxt = (state_nxt == LOCKED);
        pv_nxt   = lock_nxt && in_win;
        x_nxt    = '0;
        y_nxt    = '0;
        d_nxt    = '0;
        if (pv_nxt) begin
            x_nxt = XW'(h_cnt - H_LO);
            y_nxt = YW'(v_cnt - V_LO);
            d_nxt = d_q;
        end
        fs_nxt = pv_nxt && (x_nxt == '0) && (y_nxt == '0);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pix_valid_r   <= 1'b0;
            pix_x_r       <= '0;
            pix_y_r       <= '0;
            pix_data_r    <= '0;
            frame_start_r <= 1'b0;
            locked_r      <= 1'b0;
            h_err_r       <= 1'b0;
            v_err_r       <= 1'b0;
            err_cnt_r     <= '0;
        end else begin
            pix_valid_r   <= pv_nxt;
            pix_x_r       <= x_nxt;
            pix_y_r       <= y_nxt;
            pix_data_r    <= d_nxt;
            frame_start_r <= fs_nxt;
            locked_r      <= lock_nxt;
            h_err_r       <= h_err;
            v_err_r       <= v_err;
            if ((h_err || v_err) && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign bus.pix_valid   = pix_valid_r;
    assign bus.pix_x       = pix_x_r;
    assign bus.pix_y       = pix_y_r;
    assign bus.pix_data    = pix_data_r;
    assign bus.frame_start = frame_start_r;
    assign bus.locked      = locked_r;
    assign bus.h_err       = h_err_r;
    assign bus.v_err       = v_err_r;
    assign bus.err_cnt     = err_cnt_r;

`ifdef VGA_DEC_CRC_EN
    logic last_pix, frame_ok_r, crc_valid_r;

    vga_frame_crc #(
        .PIXEL_W (PIXEL_W)
    ) u_crc (
        .clk   (clk),
        .nRst  (nRst),
        .pixel (pix_data_r),
        .valid (pix_valid_r),
        .clear (frame_start_r),
        .crc   (bus.frame_crc)
    );

    assign last_pix = pix_valid_r
                   && (pix_x_r == XW'(H_ACTIVE - 1))
                   && (pix_y_r == YW'(V_ACTIVE - 1));

    // frame_ok survives only if lock held from frame_start to the last pixel.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            frame_ok_r  <= 1'b0;
            crc_valid_r <= 1'b0;
        end else begin
            if (frame_start_r) begin
                frame_ok_r <= 1'b1;
            end else if (!locked_r) begin
                frame_ok_r <= 1'b0;
            end
            crc_valid_r <= last_pix && (frame_ok_r || frame_start_r);
        end
    end

    assign bus.crc_valid = crc_valid_r;
`else
    // Plain decoder: no CRC engine, no CRC outputs.
`endif

endmodule
